// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) memory arbiter with block fills and single-word writes.
// Define ARB_ROUND_ROBIN_EN to alternate ties between requesters; otherwise D always wins ties.
module mem_arbiter #(
   parameter int unsigned BLOCK_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        grant_i,
   output logic        grant_d,
   output logic        fill_valid_i,
   output logic        fill_valid_d,
   output logic [15:0] fill_data,
   output logic [15:0] fill_addr,
   output logic        done_i,
   output logic        done_d
);

   localparam int unsigned LW          = $clog2(BLOCK_WORDS);
   localparam logic [15:0] BASE_MASK   = ~16'(2 * BLOCK_WORDS - 1);
   localparam logic [LW-1:0] ISSUE_LAST = LW'(BLOCK_WORDS - 1);
   localparam logic [LW:0]   RET_FULL   = (LW + 1)'(BLOCK_WORDS);

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t        state;
   logic          owner_d;
   logic [15:0]   addr_q;
   logic [LW-1:0] issue_cnt;
   logic [LW:0]   ret_cnt;
`ifdef ARB_ROUND_ROBIN_EN
   logic          last_served_d;
`endif

   logic          win_any;
   logic          win_d;
   logic          beat_ok;
   logic [LW-1:0] issue_nxt;
   logic [15:0]   block_base;

   // Winner selection and beat qualification.
   always_comb begin
      win_any = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
      win_d   = d_req & (~i_req | ~last_served_d);
`else
      win_d   = d_req;
`endif
      beat_ok    = (state == FILL) && mem_rvalid && (ret_cnt < RET_FULL);
      issue_nxt  = issue_cnt + LW'(1);
      block_base = addr_q & BASE_MASK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         owner_d      <= 1'b0;
         addr_q       <= '0;
         issue_cnt    <= '0;
         ret_cnt      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_served_d <= 1'b0;
`endif
         mem_en       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         grant_i      <= 1'b0;
         grant_d      <= 1'b0;
         fill_valid_i <= 1'b0;
         fill_valid_d <= 1'b0;
         fill_data    <= '0;
         fill_addr    <= '0;
         done_i       <= 1'b0;
         done_d       <= 1'b0;
      end else begin
         done_i       <= 1'b0;
         done_d       <= 1'b0;
         fill_valid_i <= 1'b0;
         fill_valid_d <= 1'b0;
         fill_data    <= '0;
         fill_addr    <= '0;
         case (state)
            IDLE: begin
               if (win_any) begin
                  owner_d   <= win_d;
                  addr_q    <= win_d ? d_addr : i_addr;
                  issue_cnt <= '0;
                  ret_cnt   <= '0;
                  grant_i   <= ~win_d;
                  grant_d   <= win_d;
                  mem_en    <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                  last_served_d <= win_d;
`endif
                  if (win_d && d_wr) begin
                     state     <= WRITE;
                     mem_wr    <= 1'b1;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     state    <= FILL;
                     mem_addr <= (win_d ? d_addr : i_addr) & BASE_MASK;
                  end
               end
            end
            FILL: begin
               // Issue side: one read per cycle, stop after the last word.
               if (mem_en) begin
                  if (issue_cnt != ISSUE_LAST) begin
                     issue_cnt <= issue_nxt;
                     mem_addr  <= block_base | 16'({issue_nxt, 1'b0});
                  end else begin
                     mem_en   <= 1'b0;
                     mem_addr <= '0;
                  end
               end
               // Return side: forward beats, then close out one cycle after the last.
               if (beat_ok) begin
                  fill_valid_i <= ~owner_d;
                  fill_valid_d <= owner_d;
                  fill_data    <= mem_rdata;
                  fill_addr    <= block_base | 16'({ret_cnt[LW-1:0], 1'b0});
                  ret_cnt      <= ret_cnt + (LW + 1)'(1);
               end else if (ret_cnt == RET_FULL) begin
                  state     <= IDLE;
                  done_i    <= ~owner_d;
                  done_d    <= owner_d;
                  grant_i   <= 1'b0;
                  grant_d   <= 1'b0;
                  mem_en    <= 1'b0;
                  mem_addr  <= '0;
                  issue_cnt <= '0;
                  ret_cnt   <= '0;
               end
            end
            WRITE: begin
               state     <= IDLE;
               mem_en    <= 1'b0;
               mem_wr    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               grant_i   <= 1'b0;
               grant_d   <= 1'b0;
               done_d    <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction table plus reset, request-drop and tie sequences.
module tb_mem_arbiter;

   localparam int BW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic        mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        grant_i, grant_d, fill_valid_i, fill_valid_d, done_i, done_d;
   logic [15:0] fill_data, fill_addr;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .grant_i(grant_i), .grant_d(grant_d),
      .fill_valid_i(fill_valid_i), .fill_valid_d(fill_valid_d),
      .fill_data(fill_data), .fill_addr(fill_addr),
      .done_i(done_i), .done_d(done_d)
   );

   always #5 clk = ~clk;

   // Memory model: read issued in cycle c returns rvalid in cycle c+3.
   logic [2:0]  rv_pipe = 3'b000;
   logic [15:0] a_pipe0, a_pipe1, a_pipe2;
   logic        stray = 1'b0;

   always @(posedge clk) begin
      rv_pipe <= {rv_pipe[1:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
      a_pipe0 <= mem_addr;
      a_pipe1 <= a_pipe0;
      a_pipe2 <= a_pipe1;
   end

   assign mem_rvalid = rv_pipe[2] | stray;
   assign mem_rdata  = rv_pipe[2] ? (a_pipe2 ^ 16'hA5A5) : 16'h5A5A;

   logic [71:0] outs;
   assign outs = {grant_i, grant_d, fill_valid_i, fill_valid_d, done_i, done_d, mem_en, mem_wr,
                  mem_addr, mem_wdata, fill_addr, fill_data};

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected output bundle for cycle 'cyc' after the request was sampled.
   function automatic logic [71:0] exp_at(input bit is_d, input bit wr, input logic [15:0] base,
                                          input logic [15:0] wd, input int cyc);
      logic gi = 0, gd = 0, fvi = 0, fvd = 0, di = 0, dd = 0, en = 0, mw = 0;
      logic [15:0] ma = '0, mwd = '0, fa = '0, fd = '0;
      if (wr) begin
         if (cyc == 1) begin gd = 1; en = 1; mw = 1; ma = base; mwd = wd; end
         if (cyc == 2) dd = 1;
      end else begin
         if (cyc >= 1 && cyc <= BW + 4) begin gi = !is_d; gd = is_d; end
         if (cyc >= 1 && cyc <= BW) begin en = 1; ma = base + 16'(2 * (cyc - 1)); end
         if (cyc >= 5 && cyc <= BW + 4) begin
            fvi = !is_d; fvd = is_d;
            fa  = base + 16'(2 * (cyc - 5));
            fd  = fa ^ 16'hA5A5;
         end
         if (cyc == BW + 5) begin di = !is_d; dd = is_d; end
      end
      return {gi, gd, fvi, fvd, di, dd, en, mw, ma, mwd, fa, fd};
   endfunction

   task automatic run_txn(input string name, input bit is_d, input bit wr, input logic [15:0] base,
                          input logic [15:0] wd, input int ncyc, input int rel_cyc, input int spur_cyc);
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         check($sformatf("%s cyc%0d", name, c), outs, exp_at(is_d, wr, base, wd, c));
         if (c == rel_cyc) begin i_req = 0; d_req = 0; d_wr = 0; end
         stray = (c == spur_cyc);
      end
      stray = 0;
   endtask

   typedef struct {
      logic        i_req, d_req, d_wr;
      logic [15:0] i_addr, d_addr, d_wdata;
      logic        exp_d, exp_wr;
      logic [15:0] exp_base;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 16'h1230};
      vecs[1] = '{0, 1, 1, 16'h0000, 16'h00A2, 16'hBEEF, 1, 1, 16'h00A2};
      vecs[2] = '{0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'hFFF0};
      vecs[3] = '{1, 0, 0, 16'h000E, 16'h0000, 16'h0000, 0, 0, 16'h0000};
      vecs[4] = '{0, 1, 1, 16'h0000, 16'h8001, 16'h1234, 1, 1, 16'h8001};
      vecs[5] = '{1, 0, 1, 16'hABCD, 16'h7777, 16'h9999, 0, 0, 16'hABC0};

      rst = 1; i_req = 0; d_req = 0; d_wr = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (4) @(posedge clk);
      #1;
      check("reset state", outs, 72'h0);
      rst = 0;
      @(posedge clk); #1;
      check("idle no req", outs, 72'h0);

      // Table of single transactions.
      for (int k = 0; k < 6; k++) begin
         i_req = vecs[k].i_req; d_req = vecs[k].d_req; d_wr = vecs[k].d_wr;
         i_addr = vecs[k].i_addr; d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
         run_txn($sformatf("vec%0d", k), vecs[k].exp_d, vecs[k].exp_wr, vecs[k].exp_base,
                 vecs[k].d_wdata, vecs[k].exp_wr ? 3 : BW + 6, vecs[k].exp_wr ? 1 : BW + 5, 0);
      end

      // Request dropped right after grant, address changed, and a spurious 9th beat.
      i_req = 1; i_addr = 16'h4446;
      run_txn("drop", 0, 0, 16'h4440, 16'h0, 1, 1, 0);
      i_addr = 16'h9990;
      for (int c = 2; c <= BW + 6; c++) begin
         @(posedge clk); #1;
         check($sformatf("drop cyc%0d", c), outs, exp_at(0, 0, 16'h4440, 16'h0, c));
         stray = (c == BW + 4);
      end
      stray = 0;

      // Reset at fill beat 3, then stray rvalids while idle.
      i_req = 1; i_addr = 16'h1234;
      run_txn("rstpre", 0, 0, 16'h1230, 16'h0, 8, 8, 0);
      rst = 1;
      @(posedge clk); #1;
      check("rst mid fill", outs, 72'h0);
      rst = 0;
      for (int c = 10; c <= 15; c++) begin
         @(posedge clk); #1;
         check($sformatf("rst stray cyc%0d", c), outs, 72'h0);
         stray = (c == 11);
      end
      stray = 0;
      i_req = 1; i_addr = 16'h1234;
      run_txn("rstpost", 0, 0, 16'h1230, 16'h0, BW + 6, BW + 5, 0);

      // Held tie between I and D fills, back-to-back.
      rst = 1;
      @(posedge clk); #1;
      check("tie reset", outs, 72'h0);
      rst = 0;
      i_req = 1; d_req = 1; d_wr = 0; i_addr = 16'h0100; d_addr = 16'h0206;
      for (int k = 0; k < 4; k++) begin
         bit exp_d;
`ifdef ARB_ROUND_ROBIN_EN
         exp_d = (k % 2 == 0);
`else
         exp_d = 1;
`endif
         run_txn($sformatf("tie%0d", k), exp_d, 0, exp_d ? 16'h0200 : 16'h0100, 16'h0,
                 BW + 5, (k == 3) ? BW + 5 : 0, 0);
      end
      @(posedge clk); #1;
      check("tie end idle", outs, 72'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 8: 16-bit words per cache block fill; power of 2, at least 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_req  input  1  I-cache miss fill request (level).
REQ-005 SHALL have port i_addr  input  16  I-cache miss byte address.
REQ-006 SHALL have port d_req  input  1  D-cache request (level).
REQ-007 SHALL have port d_wr  input  1  D-cache request type: 1 = single-word write, 0 = block fill.
REQ-008 SHALL have port d_addr  input  16  D-cache byte address.
REQ-009 SHALL have port d_wdata  input  16  D-cache write data.
REQ-010 SHALL have port mem_rdata  input  16  memory read data.
REQ-011 SHALL have port mem_rvalid  input  1  memory read data valid.
REQ-012 SHALL have port mem_en  output  1  memory access enable.
REQ-013 SHALL have port mem_wr  output  1  memory write strobe.
REQ-014 SHALL have port mem_addr  output  16  memory byte address.
REQ-015 SHALL have port mem_wdata  output  16  memory write data.
REQ-016 SHALL have ports grant_i and grant_d  output  1 each  requester currently owns memory.
REQ-017 SHALL have ports fill_valid_i and fill_valid_d  output  1 each  fill beat valid for that requester.
REQ-018 SHALL have port fill_data  output  16  equal to mem_rdata.
REQ-019 SHALL have port fill_addr  output  16  byte address of the current fill beat.
REQ-020 SHALL have ports done_i and done_d  output  1 each  one-cycle transaction-complete pulse.

Function
REQ-021 SHALL implement the states IDLE, FILL and WRITE.
REQ-022 In IDLE, the request winner SHALL be latched: owner, address and d_wdata; the next cycle SHALL be FILL, or WRITE when the winner is D with d_wr=1.
REQ-023 In FILL, the block SHALL drive mem_en=1 and mem_wr=0 for exactly BLOCK_WORDS consecutive cycles.
- mem_addr = {addr[15:log2(BLOCK_WORDS)+1], issue_cnt, 1'b0}.
- issue_cnt runs 0..BLOCK_WORDS-1.
REQ-024 In FILL, the block SHALL count mem_rvalid beats (ret_cnt); on each beat:
- fill_valid of the owner = 1;
- fill_addr = block base | {ret_cnt, 1'b0}.
REQ-025 The cycle after beat BLOCK_WORDS-1, the block SHALL pulse the owner's done, drop grant and be in IDLE.
REQ-026 In WRITE, the block SHALL drive mem_en=1, mem_wr=1, the latched address and the latched wdata for one cycle; done_d and IDLE SHALL follow the next cycle.
REQ-027 grant_x SHALL be high exactly while in FILL or WRITE for owner x; at most one grant SHALL be high.
REQ-028 Requests SHALL be sampled only in IDLE, including the done cycle; a new grant SHALL start the cycle after done.
REQ-029 Deasserting a request or changing the address mid-transaction SHALL be ignored; the transaction SHALL complete.
REQ-030 mem_rvalid outside FILL, or beyond BLOCK_WORDS beats, SHALL be ignored: no fill_valid, no counter change.
REQ-031 The counters SHALL wrap-free saturate: issue_cnt stops at the last word, and the block SHALL never issue more than BLOCK_WORDS reads per fill.
REQ-032 Outputs SHALL be 0 whenever not defined above.

Reset
REQ-033 When rst=1 at an edge, the block SHALL go to IDLE, clear the counters and owner, and set last_served=I, even mid-transaction.
REQ-034 When rst=1 at an edge, the block SHALL drive all outputs to 0 from the next cycle.
REQ-035 Memory beats still in flight after reset SHALL be ignored, per REQ-030.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not in last_served; last_served updates at each grant.
REQ-037 Without ARB_ROUND_ROBIN_EN, D SHALL always win ties (fixed priority), and last_served SHALL be absent.

Verification
REQ-038 Fill scenario:
- Stimulus: i_req=1, i_addr=0x1234, memory latency 4.
- Response: grant_i at T+1; mem_addr 0x1230..0x123E on T+1..T+8; fill_valid_i T+5..T+12 with fill_addr 0x1230..0x123E; done_i at T+13.
REQ-039 Write scenario:
- Stimulus: d_req=1, d_wr=1, d_addr=0x00A2, d_wdata=0xBEEF.
- Response: a single cycle of mem_en=mem_wr=1 at 0x00A2 with 0xBEEF; done_d on the next cycle.
REQ-040 Tie scenario:
- Stimulus: i_req and d_req both held, repeated back-to-back.
- Response without the macro: only D is served.
- Response with the macro: D, I, D, I alternate; each new grant starts the cycle after the previous done.
REQ-041 Reset scenario:
- Stimulus: rst pulsed at fill beat 3; four stray mem_rvalid follow.
- Response: all outputs 0 and no fill_valid; the next i_req restarts from word 0.
REQ-042 Request-drop scenario:
- Stimulus: i_req dropped after the grant, plus a 9th spurious rvalid.
- Response: the fill completes with 8 beats; the extra beat is ignored; exactly one done_i.
